control_fsm: RTL and testbench

- Multi-cycle main control unit that sits opposite the MIPS datapath. It consumes the datapath's decoded opcode, funct and ALU zero flag.
- It drives the datapath's stage enable and its control inputs: RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg.
- It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- It flags unsupported encodings, counts retired instructions and raises the branch PC-select.

---
 rtl/control_fsm.sv | 159 +++++++++++++++
 tb/tb_control_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle main control unit for the MIPS datapath: sequences each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath control lines.
//
// state     | meaning
// IDLE      | waiting for c_i_run
// FETCH     | fetch enable pulse
// DECODE    | latch instruction class, trap unsupported encodings
// EXECUTE   | ALU op; BEQ resolves and retires here
// MEM       | data memory access (LW read, SW write and retire)
// WRITEBACK | register file write, retire
// TRAP      | sticky illegal state, left only by reset
module control_fsm #(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    c_i_run,
    input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  c_i_funct,
    input  logic                    c_i_zero,
    output logic                    c_o_ce,
    output logic                    c_o_RegDst,
    output logic                    c_o_RegWrite,
    output logic                    c_o_ALUSrc,
    output logic                    c_o_MemRead,
    output logic                    c_o_MemWrite,
    output logic                    c_o_MemtoReg,
    output logic                    c_o_pc_src,
    output logic                    c_o_illegal,
    output logic [2:0]              c_o_state,
    output logic [CNT_WIDTH-1:0]    c_o_instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_RTYPE = 3'd1,
        C_IALU  = 3'd2,
        C_LW    = 3'd3,
        C_SW    = 3'd4,
        C_BEQ   = 3'd5
    } class_t;

    state_t                 r_state;
    class_t                 r_class;
    logic                   r_illegal;
    logic [CNT_WIDTH-1:0]   r_instr_count;

    class_t                 w_dec_class;
    logic                   w_active;

    always_comb begin
        w_dec_class = C_NONE;
        if (c_i_opcode == OPCODE_WIDTH'(6'h00)) begin
            case (c_i_funct)
                FUNCT_WIDTH'(6'h20),
                FUNCT_WIDTH'(6'h22),
                FUNCT_WIDTH'(6'h24),
                FUNCT_WIDTH'(6'h25),
                FUNCT_WIDTH'(6'h2A): w_dec_class = C_RTYPE;
                default:             w_dec_class = C_NONE;
            endcase
        end else begin
            case (c_i_opcode)
                OPCODE_WIDTH'(6'h08),
                OPCODE_WIDTH'(6'h0A),
                OPCODE_WIDTH'(6'h0C),
                OPCODE_WIDTH'(6'h0D): w_dec_class = C_IALU;
                OPCODE_WIDTH'(6'h23): w_dec_class = C_LW;
                OPCODE_WIDTH'(6'h2B): w_dec_class = C_SW;
                OPCODE_WIDTH'(6'h04): w_dec_class = C_BEQ;
                default:              w_dec_class = C_NONE;
            endcase
        end
    end

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            r_state       <= S_IDLE;
            r_class       <= C_NONE;
            r_illegal     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (c_i_run) r_state <= S_FETCH;
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_class <= w_dec_class;
                    if (w_dec_class == C_NONE) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (r_class)
                        C_RTYPE, C_IALU: r_state <= S_WRITEBACK;
                        C_LW, C_SW:      r_state <= S_MEM;
                        C_BEQ: begin
                            r_instr_count <= r_instr_count + 1'b1;
                            r_state       <= c_i_run ? S_FETCH : S_IDLE;
                        end
                        default: begin
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (r_class == C_LW) begin
                        r_state <= S_WRITEBACK;
                    end else begin
                        r_instr_count <= r_instr_count + 1'b1;
                        r_state       <= c_i_run ? S_FETCH : S_IDLE;
                    end
                end
                S_WRITEBACK: begin
                    r_instr_count <= r_instr_count + 1'b1;
                    r_state       <= c_i_run ? S_FETCH : S_IDLE;
                end
                S_TRAP: r_state <= S_TRAP;
                default: begin
                    r_state   <= S_TRAP;
                    r_illegal <= 1'b1;
                end
            endcase
        end
    end

    // Static controls follow the latched class only while an instruction is in flight.
    assign w_active = (r_state == S_EXECUTE) || (r_state == S_MEM) || (r_state == S_WRITEBACK);

    assign c_o_ce          = (r_state == S_FETCH);
    assign c_o_RegDst      = w_active && (r_class == C_RTYPE);
    assign c_o_ALUSrc      = w_active && ((r_class == C_IALU) || (r_class == C_LW) || (r_class == C_SW));
    assign c_o_MemtoReg    = w_active && (r_class == C_LW);
    assign c_o_RegWrite    = (r_state == S_WRITEBACK);
    assign c_o_MemRead     = (r_state == S_MEM) && (r_class == C_LW);
    assign c_o_MemWrite    = (r_state == S_MEM) && (r_class == C_SW);
    assign c_o_pc_src      = (r_state == S_EXECUTE) && (r_class == C_BEQ) && c_i_zero;
    assign c_o_illegal     = r_illegal;
    assign c_o_state       = r_state;
    assign c_o_instr_count = r_instr_count;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-instruction expected cycle traces are queued
// when an instruction is issued and compared cycle by cycle against the outputs.
module tb_control_fsm;

    logic        c_clk = 1'b0;
    logic        c_rst;
    logic        c_i_run;
    logic [5:0]  c_i_opcode;
    logic [5:0]  c_i_funct;
    logic        c_i_zero;
    logic        c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc;
    logic        c_o_MemRead, c_o_MemWrite, c_o_MemtoReg, c_o_pc_src, c_o_illegal;
    logic [2:0]  c_o_state;
    logic [31:0] c_o_instr_count;

    // narrow-counter instance used to exercise counter wrap
    logic        w_rst;
    logic        w_run;
    logic [5:0]  w_opcode = 6'h04;
    logic [5:0]  w_funct  = 6'h00;
    logic        w_zero   = 1'b0;
    logic        w_ce, w_rd, w_rw, w_as, w_mr, w_mw, w_m2r, w_pc, w_ill;
    logic [2:0]  w_state;
    logic [3:0]  w_count;

    always #5 c_clk = ~c_clk;

    control_fsm dut (
        .c_clk(c_clk), .c_rst(c_rst), .c_i_run(c_i_run),
        .c_i_opcode(c_i_opcode), .c_i_funct(c_i_funct), .c_i_zero(c_i_zero),
        .c_o_ce(c_o_ce), .c_o_RegDst(c_o_RegDst), .c_o_RegWrite(c_o_RegWrite),
        .c_o_ALUSrc(c_o_ALUSrc), .c_o_MemRead(c_o_MemRead), .c_o_MemWrite(c_o_MemWrite),
        .c_o_MemtoReg(c_o_MemtoReg), .c_o_pc_src(c_o_pc_src), .c_o_illegal(c_o_illegal),
        .c_o_state(c_o_state), .c_o_instr_count(c_o_instr_count)
    );

    control_fsm #(.CNT_WIDTH(4)) dut_w (
        .c_clk(c_clk), .c_rst(w_rst), .c_i_run(w_run),
        .c_i_opcode(w_opcode), .c_i_funct(w_funct), .c_i_zero(w_zero),
        .c_o_ce(w_ce), .c_o_RegDst(w_rd), .c_o_RegWrite(w_rw),
        .c_o_ALUSrc(w_as), .c_o_MemRead(w_mr), .c_o_MemWrite(w_mw),
        .c_o_MemtoReg(w_m2r), .c_o_pc_src(w_pc), .c_o_illegal(w_ill),
        .c_o_state(w_state), .c_o_instr_count(w_count)
    );

    localparam logic [8:0] B_CE  = 9'h100;
    localparam logic [8:0] B_RD  = 9'h080;
    localparam logic [8:0] B_RW  = 9'h040;
    localparam logic [8:0] B_AS  = 9'h020;
    localparam logic [8:0] B_MR  = 9'h010;
    localparam logic [8:0] B_MW  = 9'h008;
    localparam logic [8:0] B_M2R = 9'h004;
    localparam logic [8:0] B_PC  = 9'h002;
    localparam logic [8:0] B_ILL = 9'h001;

    typedef struct {
        logic [63:0] v;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_count = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {20'd0, c_o_state, c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc,
                c_o_MemRead, c_o_MemWrite, c_o_MemtoReg, c_o_pc_src, c_o_illegal,
                c_o_instr_count};
    endfunction

    function automatic logic [63:0] ev(input logic [2:0] st, input logic [8:0] ctl,
                                       input logic [31:0] cnt);
        return {20'd0, st, ctl, cnt};
    endfunction

    task automatic push(input logic [2:0] st, input logic [8:0] ctl, input string tag);
        exp_t e;
        e.v   = ev(st, ctl, m_count);
        e.tag = tag;
        q.push_back(e);
    endtask

    // Pops one expectation per cycle; inputs are applied in FETCH, run is updated in EXECUTE.
    task automatic drain(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic run_after);
        exp_t e;
        int   idx = 0;
        while (q.size() > 0) begin
            @(negedge c_clk);
            if (idx == 0) begin
                c_i_opcode = op;
                c_i_funct  = fn;
                c_i_zero   = z;
            end
            e = q.pop_front();
            chk(e.tag, obs(), e.v);
            if (idx == 2) c_i_run = run_after;
            idx++;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic run_after, input string name);
        push(3'd1, B_CE, {name, ".fetch"});
        push(3'd2, 9'h0, {name, ".decode"});
        if (op == 6'h00) begin
            push(3'd3, B_RD, {name, ".exec"});
            push(3'd5, B_RD | B_RW, {name, ".wb"});
        end else if (op == 6'h23) begin
            push(3'd3, B_AS | B_M2R, {name, ".exec"});
            push(3'd4, B_AS | B_M2R | B_MR, {name, ".mem"});
            push(3'd5, B_AS | B_M2R | B_RW, {name, ".wb"});
        end else if (op == 6'h2B) begin
            push(3'd3, B_AS, {name, ".exec"});
            push(3'd4, B_AS | B_MW, {name, ".mem"});
        end else if (op == 6'h04) begin
            push(3'd3, z ? B_PC : 9'h0, {name, ".exec"});
        end else begin
            push(3'd3, B_AS, {name, ".exec"});
            push(3'd5, B_AS | B_RW, {name, ".wb"});
        end
        m_count = m_count + 1;
        drain(op, fn, z, run_after);
    endtask

    task automatic run_trap(input logic [5:0] op, input logic [5:0] fn, input string name);
        push(3'd1, B_CE, {name, ".fetch"});
        push(3'd2, 9'h0, {name, ".decode"});
        for (int i = 0; i < 4; i++) push(3'd7, B_ILL, {name, ".trap"});
        drain(op, fn, 1'b0, 1'b1);
    endtask

    task automatic expect_idle(input int n, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) push(3'd0, 9'h0, name);
        while (q.size() > 0) begin
            @(negedge c_clk);
            e = q.pop_front();
            chk(e.tag, obs(), e.v);
        end
    endtask

    task automatic apply_reset(input string name);
        c_rst   = 1'b0;
        c_i_run = 1'b0;
        m_count = 0;
        @(negedge c_clk);
        chk(name, obs(), ev(3'd0, 9'h0, 32'd0));
        c_rst = 1'b1;
    endtask

    initial begin
        c_rst      = 1'b0;
        c_i_run    = 1'b0;
        c_i_opcode = 6'h00;
        c_i_funct  = 6'h00;
        c_i_zero   = 1'b0;
        w_rst      = 1'b0;
        w_run      = 1'b0;
        repeat (2) @(negedge c_clk);
        chk("reset", obs(), ev(3'd0, 9'h0, 32'd0));
        c_rst = 1'b1;
        expect_idle(2, "idle_hold");

        c_i_run = 1'b1;
        run_instr(6'h00, 6'h20, 1'b0, 1'b1, "add");
        run_instr(6'h23, 6'h00, 1'b0, 1'b1, "lw");
        run_instr(6'h2B, 6'h00, 1'b0, 1'b1, "sw");
        run_instr(6'h04, 6'h00, 1'b1, 1'b1, "beq_t");
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, "beq_nt");
        run_instr(6'h00, 6'h22, 1'b1, 1'b1, "sub");
        run_instr(6'h00, 6'h2A, 1'b0, 1'b1, "slt");
        run_instr(6'h0D, 6'h3F, 1'b0, 1'b1, "ori");
        run_instr(6'h0A, 6'h00, 1'b0, 1'b1, "slti");
        run_instr(6'h08, 6'h00, 1'b0, 1'b0, "addi_drop");
        expect_idle(2, "idle_after_drop");
        c_i_run = 1'b1;
        run_instr(6'h00, 6'h24, 1'b0, 1'b1, "and");
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, "sw_drop");
        expect_idle(1, "idle_after_sw");

        // asynchronous reset in the middle of a load's MEM cycle
        c_i_opcode = 6'h23;
        c_i_funct  = 6'h00;
        c_i_run    = 1'b1;
        repeat (4) @(negedge c_clk);
        chk("lw_mem_pre_reset", obs(), ev(3'd4, B_AS | B_M2R | B_MR, m_count));
        #2 c_rst = 1'b0;
        #1 chk("async_reset", obs(), ev(3'd0, 9'h0, 32'd0));
        c_i_run = 1'b0;
        m_count = 0;
        @(negedge c_clk);
        c_rst = 1'b1;
        expect_idle(1, "idle_after_async");

        c_i_run = 1'b1;
        run_trap(6'h3F, 6'h00, "trap_op3f");
        apply_reset("reset_clears_illegal");
        c_i_run = 1'b1;
        run_instr(6'h00, 6'h25, 1'b0, 1'b1, "or");
        run_trap(6'h00, 6'h08, "trap_funct08");
        apply_reset("reset_after_trap");

        // BEQ stream on a 4-bit counter: count k is visible after 1+3k edges
        @(negedge c_clk);
        w_rst = 1'b1;
        w_run = 1'b1;
        repeat (1 + 3 * 15) @(negedge c_clk);
        chk("wrap_pre", {57'd0, w_state, w_count}, {57'd0, 3'd1, 4'd15});
        repeat (3) @(negedge c_clk);
        chk("wrap_zero", {57'd0, w_state, w_count}, {57'd0, 3'd1, 4'd0});
        repeat (3) @(negedge c_clk);
        chk("wrap_one", {57'd0, w_state, w_count}, {57'd0, 3'd1, 4'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
